// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback definitions: width helpers, traceback FSM states and
// the survivor-path predecessor step.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    DECODE,
    DRAIN
  } tb_fsm_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int time_width(input int n_rows);
    return (clog2(n_rows) < 1) ? 1 : clog2(n_rows);
  endfunction

  function automatic int state_width(input int k);
    return k - 1;
  endfunction

  // Older history moves up one position; the survivor bit becomes the oldest bit.
  function automatic logic [31:0] predecessor(input logic [31:0] s, input int m,
                                              input logic surv_bit);
    return ((s << 1) | {31'd0, surv_bit}) & ((32'd1 << m) - 32'd1);
  endfunction

endpackage

// File: rtl/tb_lifo.sv
// L-deep bit stack that reverses the newest-first traceback decisions into
// chronological order.
module tb_lifo
  import viterbi_pkg::*;
#(
  parameter int L = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic top_bit,
  output logic empty,
  output logic one_left
);

  localparam int CW = clog2(L + 1);

  logic [CW-1:0] cnt_q;
  logic [L-1:0]  mem_q;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (push && cnt_q != CW'(L)) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      if (push && cnt_q == CW'(i)) mem_q[i] <= push_bit;
    end
  end

  // NOTE: defaulting every always_comb output first keeps the block latch-free.
  always_comb begin
    top_bit = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (cnt_q == CW'(i + 1)) top_bit = mem_q[i];
    end
  end

  assign empty    = (cnt_q == '0);
  assign one_left = (cnt_q == CW'(1));

endmodule

// File: rtl/traceback_block.sv
// Block-mode Viterbi traceback: D merge steps, L decode steps through the
// survivor ring, then L decoded bits streamed oldest-first.
module traceback_block
  import viterbi_pkg::*;
#(
  parameter int K = 3,
  parameter int D = 6,
  parameter int L = 4,
  localparam int M = state_width(K),
  localparam int N_ROWS = D + L,
  localparam int TIME_W = time_width(D + L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] start_time,
  input  logic [M-1:0]      start_state,
  input  logic              force_state0,
  output logic [TIME_W-1:0] tb_time,
  output logic [M-1:0]      tb_state,
  input  logic              tb_surv_bit,
  output logic              busy,
  output logic              start_drop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  localparam int CNT_W = clog2((D > L) ? D : L) + 1;

  tb_fsm_e           fsm_q;
  logic [TIME_W-1:0] row_q;
  logic [TIME_W-1:0] row_prev;
  logic [M-1:0]      state_q;
  logic [M-1:0]      state_pred;
  logic [CNT_W-1:0]  cnt_q;
  logic              drop_q;
  logic              pop;
  logic              lifo_top;
  logic              lifo_empty;
  logic              lifo_one_left;

  // The survivor ring is walked backwards in time, wrapping below row 0.
  assign row_prev   = (row_q == '0) ? TIME_W'(N_ROWS - 1) : row_q - TIME_W'(1);
  assign state_pred = M'(predecessor(32'(state_q), M, tb_surv_bit));
  assign pop        = out_valid & out_ready;

  tb_lifo #(.L(L)) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fsm_q == DECODE),
    .push_bit (state_q[M-1]),
    .pop      (pop),
    .top_bit  (lifo_top),
    .empty    (lifo_empty),
    .one_left (lifo_one_left)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      row_q   <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= start && (fsm_q != IDLE);
      case (fsm_q)
        IDLE: begin
          if (start) begin
            row_q   <= start_time;
            state_q <= force_state0 ? '0 : start_state;
            cnt_q   <= '0;
            fsm_q   <= MERGE;
          end
        end
        MERGE: begin
          row_q   <= row_prev;
          state_q <= state_pred;
          if (cnt_q == CNT_W'(D - 1)) begin
            cnt_q <= '0;
            fsm_q <= DECODE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DECODE: begin
          row_q   <= row_prev;
          state_q <= state_pred;
          if (cnt_q == CNT_W'(L - 1)) begin
            cnt_q <= '0;
            fsm_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (pop && lifo_one_left) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign tb_time    = row_q;
  assign tb_state   = state_q;
  assign busy       = (fsm_q != IDLE);
  assign start_drop = drop_q;
  assign out_valid  = (fsm_q == DRAIN) && !lifo_empty;
  assign out_bit    = lifo_top;
  assign out_last   = out_valid && lifo_one_left;

endmodule

// File: tb/tb_traceback_block.sv
// Randomised self-checking bench for traceback_block against a survivor-path
// walk computed directly from the traceback rules.
module tb_traceback_block;

  localparam int K      = 3;
  localparam int D      = 6;
  localparam int L      = 4;
  localparam int M      = K - 1;
  localparam int S      = 1 << M;
  localparam int N_ROWS = D + L;
  localparam int TW     = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [TW-1:0] start_time;
  logic [M-1:0]  start_state;
  logic          force_state0;
  logic [TW-1:0] tb_time;
  logic [M-1:0]  tb_state;
  logic          tb_surv_bit;
  logic          busy;
  logic          start_drop;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;

  bit surv [N_ROWS][S];

  int n_checks = 0;
  int n_errors = 0;

  // Model state shared between the compare process and the stimulus.
  int  exp_time[$];
  int  exp_state[$];
  bit  exp_bits[$];
  bit  m_busy = 0;
  bit  post_rst = 0;
  bit  exp_drop = 0;
  bit  busy_now;
  int  k = 0;
  int  first_k = 0;
  int  drain_cycles = 0;

  traceback_block #(.K(K), .D(D), .L(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_time   (start_time),
    .start_state  (start_state),
    .force_state0 (force_state0),
    .tb_time      (tb_time),
    .tb_state     (tb_state),
    .tb_surv_bit  (tb_surv_bit),
    .busy         (busy),
    .start_drop   (start_drop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tb_surv_bit = (tb_time < N_ROWS) ? surv[tb_time][tb_state] : 1'b0;

  always @(posedge clk) begin
    if (start && !rst) assert (start_time < N_ROWS) else $error("start_time out of range");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Walk D+L rows newest-first; the last L visited states give the decoded
  // bits, released in reverse visiting order (oldest row first).
  task automatic model_block(input int st, input int init);
    int row;
    int s;
    exp_time.delete();
    exp_state.delete();
    exp_bits.delete();
    row = st;
    s   = init;
    for (int i = 0; i < D + L; i++) begin
      exp_time.push_back(row);
      exp_state.push_back(s);
      if (i >= D) exp_bits.push_front(bit'((s >> (M - 1)) & 1));
      s   = ((s << 1) | int'(surv[row][s])) & (S - 1);
      row = (row == 0) ? N_ROWS - 1 : row - 1;
    end
  endtask

  task automatic fill_parity();
    for (int t = 0; t < N_ROWS; t++)
      for (int j = 0; j < S; j++) surv[t][j] = bit'(t % 2);
  endtask

  task automatic fill_ones();
    for (int t = 0; t < N_ROWS; t++)
      for (int j = 0; j < S; j++) surv[t][j] = 1'b1;
  endtask

  task automatic fill_random();
    for (int t = 0; t < N_ROWS; t++)
      for (int j = 0; j < S; j++) surv[t][j] = bit'($urandom_range(1));
  endtask

  function automatic int pack_bits();
    int v;
    v = 0;
    foreach (exp_bits[i]) v = (v << 1) | int'(exp_bits[i]);
    return v;
  endfunction

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    busy_now = m_busy;
    if (post_rst) begin
      check("rst_tb_time", 32'(tb_time), 0);
      check("rst_tb_state", 32'(tb_state), 0);
      check("rst_out_bit", 32'(out_bit), 0);
      check("rst_out_last", 32'(out_last), 0);
    end
    post_rst = 0;
    check("busy", 32'(busy), 32'(busy_now));
    check("start_drop", 32'(start_drop), 32'(exp_drop));
    if (busy_now) begin
      k++;
      if (k <= D + L) begin
        check("tb_time", 32'(tb_time), 32'(exp_time[k-1]));
        check("tb_state", 32'(tb_state), 32'(exp_state[k-1]));
        check("valid_early", 32'(out_valid), 0);
      end else begin
        if (out_valid === 1'b1 && first_k == 0) first_k = k;
        check("out_valid", 32'(out_valid), 1);
        check("out_bit", 32'(out_bit), 32'(exp_bits[0]));
        check("out_last", 32'(out_last), 32'(exp_bits.size() == 1));
        drain_cycles++;
        if (out_ready) begin
          void'(exp_bits.pop_front());
          if (exp_bits.size() == 0) m_busy = 0;
        end
      end
    end else begin
      check("valid_idle", 32'(out_valid), 0);
    end
    exp_drop = start && busy_now;
    if (rst) begin
      m_busy   = 0;
      post_rst = 1;
      exp_drop = 0;
      exp_bits.delete();
    end else if (start && !busy_now) begin
      model_block(int'(start_time), force_state0 ? 0 : int'(start_state));
      m_busy       = 1;
      k            = 0;
      first_k      = 0;
      drain_cycles = 0;
    end
  end

  // mode 0: always ready, 1: random ready and stray starts, 2: 5-cycle stall.
  task automatic run_block(input int st, input int ss, input int f, input int mode,
                           input int stray_at, input int rst_at);
    int n;
    start_time   = TW'(st);
    start_state  = M'(ss);
    force_state0 = f[0];
    out_ready    = (mode == 0);
    start        = 1'b1;
    cyc();
    start = 1'b0;
    n     = 0;
    while (m_busy && n < 300) begin
      n++;
      start = (n == stray_at) || (mode == 1 && $urandom_range(7) == 0);
      rst   = (n == rst_at);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'(($urandom_range(1)));
        default: out_ready = (drain_cycles >= 5);
      endcase
      cyc();
    end
    start = 1'b0;
    rst   = 1'b0;
    check("block_done", 32'(m_busy), 0);
    if (rst_at < 0) check("first_valid_cycle", 32'(first_k), 32'(D + L + 1));
    cyc();
  endtask

  initial begin
    int lit_times[N_ROWS];
    rst          = 1'b1;
    start        = 1'b0;
    start_time   = '0;
    start_state  = '0;
    force_state0 = 1'b0;
    out_ready    = 1'b0;

    // Hand-computed expectations pinning the model.
    fill_parity();
    model_block(9, 0);
    check("model_t1_bits", 32'(pack_bits()), 32'b0101);
    model_block(2, 0);
    check("model_t3_bits", 32'(pack_bits()), 32'b1010);
    lit_times = '{2, 1, 0, 9, 8, 7, 6, 5, 4, 3};
    for (int i = 0; i < N_ROWS; i++) check("model_t3_time", 32'(exp_time[i]), 32'(lit_times[i]));
    fill_ones();
    model_block(9, 3);
    check("model_t6_bits", 32'(pack_bits()), 32'b1111);
    check("model_t6_state", 32'(exp_state[D + L - 1]), 3);
    exp_bits.delete();

    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    fill_parity();
    run_block(9, 0, 1, 0, -1, -1);
    run_block(9, 0, 1, 2, -1, -1);
    run_block(2, 0, 1, 0, -1, -1);
    run_block(9, 0, 1, 0, 3, -1);
    run_block(9, 0, 1, 0, -1, 9);
    run_block(9, 0, 1, 0, -1, -1);
    fill_ones();
    run_block(9, 3, 0, 0, -1, -1);

    repeat (12) begin
      fill_random();
      run_block($urandom_range(N_ROWS - 1), $urandom_range(S - 1), $urandom_range(1), 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
